bsort_result_checker: RTL and testbench

Post-run checker sitting directly downstream of the HLS-generated `main` core in the bsort100 simulation flow. It counts accelerator cycles from start pulse to `done_port`, then reads the sorted array back through channel 0 of the core's slave memory port. It verifies the array is non-decreasing as signed 32-bit words and reports pass/fail, cycle count and first failing index. The testbench sequencer consumes these results instead of forcing `success = 1`.

---
 rtl/bsort_result_checker.sv | 137 +++++++++++++
 tb/tb_bsort_result_checker.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsort_result_checker.sv
// bsort_result_checker: times a bsort run, then reads the array
// back over slave channel 0 and checks it is non-decreasing.
module bsort_result_checker #(
  parameter int BASE_ADDR  = 0,
  parameter int N_WORDS    = 100,
  parameter int ADDR_W     = 10,
  parameter int MAX_CYCLES = 200000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              done_port,
  output logic              S_oe_ram,
  output logic              S_we_ram,
  output logic [ADDR_W-1:0] S_addr_ram,
  output logic [63:0]       S_Wdata_ram,
  output logic [6:0]        S_data_ram_size,
  input  logic [63:0]       Sout_Rdata_ram,
  input  logic              Sout_DataRdy,
  output logic              chk_done,
  output logic              chk_pass,
  output logic              chk_timeout,
  output logic [31:0]       sim_cycles,
  output logic [15:0]       err_index
);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    RD,
    WT,
    CMP,
    FIN
  } state_t;

  state_t      state;
  logic [31:0] idx;
  logic [31:0] prev;
  logic [31:0] cur;
  logic [31:0] cyc_nxt;
  logic [31:0] idx_nxt;
  logic        viol;
  logic        err_none;
  logic [31:0] unused_rdata_hi;

  assign S_we_ram        = 1'b0;
  assign S_Wdata_ram     = '0;
  assign unused_rdata_hi = Sout_Rdata_ram[63:32];

  assign cyc_nxt  = sim_cycles + 32'd1;
  assign idx_nxt  = idx + 32'd1;
  assign err_none = (err_index == 16'hFFFF);
  assign viol     = (idx != 32'd0) && ($signed(prev) > $signed(cur));

  function automatic logic [ADDR_W-1:0] rd_addr(input logic [31:0] i);
    return ADDR_W'(BASE_ADDR) + ADDR_W'(i << 2);
  endfunction

  // Sequencer: run timer, one-at-a-time read-back walk, result registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      idx             <= '0;
      prev            <= '0;
      cur             <= '0;
      S_oe_ram        <= 1'b0;
      S_addr_ram      <= '0;
      S_data_ram_size <= '0;
      chk_done        <= 1'b0;
      chk_pass        <= 1'b0;
      chk_timeout     <= 1'b0;
      sim_cycles      <= '0;
      err_index       <= 16'hFFFF;
    end else begin
      S_oe_ram        <= 1'b0;
      S_addr_ram      <= '0;
      S_data_ram_size <= '0;
      unique case (state)
        IDLE, FIN: begin
          if (start) begin
            state       <= RUN;
            chk_done    <= 1'b0;
            chk_pass    <= 1'b0;
            chk_timeout <= 1'b0;
            sim_cycles  <= 32'd1;
            err_index   <= 16'hFFFF;
            idx         <= '0;
          end
        end
        RUN: begin
          sim_cycles <= cyc_nxt;
          if (done_port) begin
            state           <= RD;
            S_oe_ram        <= 1'b1;
            S_addr_ram      <= rd_addr(32'd0);
            S_data_ram_size <= 7'd32;
          end else if (cyc_nxt >= 32'(MAX_CYCLES)) begin
            state       <= FIN;
            chk_done    <= 1'b1;
            chk_timeout <= 1'b1;
            chk_pass    <= 1'b0;
          end
        end
        RD: begin
          state <= WT;
        end
        WT: begin
          if (Sout_DataRdy) begin
            cur   <= Sout_Rdata_ram[31:0];
            state <= CMP;
          end
        end
        CMP: begin
          if (viol && err_none) begin
            err_index <= 16'(idx - 32'd1);
          end
          prev <= cur;
          idx  <= idx_nxt;
          if (idx_nxt == 32'(N_WORDS)) begin
            state    <= FIN;
            chk_done <= 1'b1;
            chk_pass <= !chk_timeout && err_none && !viol;
          end else begin
            state           <= RD;
            S_oe_ram        <= 1'b1;
            S_addr_ram      <= rd_addr(idx_nxt);
            S_data_ram_size <= 7'd32;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bsort_result_checker.sv
// Bench for bsort_result_checker: table vectors, random arrays vs a
// reference model, timeout, address wrap and reset corner cases.
`timescale 1ns/1ps
module tb_bsort_result_checker;

  localparam int N = 100;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // main instance: default parameters
  logic        start1 = 1'b0;
  logic        done1  = 1'b0;
  logic        oe1, we1, cdone1, cpass1, ctmo1;
  logic [9:0]  addr1;
  logic [63:0] wdata1;
  logic [6:0]  size1;
  logic [63:0] rdata1 = '0;
  logic        rdy1   = 1'b0;
  logic [31:0] sim1;
  logic [15:0] err1;

  // second instance: short timeout, 3 words straddling address wrap
  logic        start2 = 1'b0;
  logic        done2  = 1'b0;
  logic        oe2, we2, cdone2, cpass2, ctmo2;
  logic [9:0]  addr2;
  logic [63:0] wdata2;
  logic [6:0]  size2;
  logic [63:0] rdata2 = '0;
  logic        rdy2   = 1'b0;
  logic [31:0] sim2;
  logic [15:0] err2;

  bsort_result_checker dut1 (
    .clock(clock), .reset(reset), .start(start1), .done_port(done1),
    .S_oe_ram(oe1), .S_we_ram(we1), .S_addr_ram(addr1),
    .S_Wdata_ram(wdata1), .S_data_ram_size(size1),
    .Sout_Rdata_ram(rdata1), .Sout_DataRdy(rdy1),
    .chk_done(cdone1), .chk_pass(cpass1), .chk_timeout(ctmo1),
    .sim_cycles(sim1), .err_index(err1)
  );

  bsort_result_checker #(
    .BASE_ADDR(1016), .N_WORDS(3), .ADDR_W(10), .MAX_CYCLES(50)
  ) dut2 (
    .clock(clock), .reset(reset), .start(start2), .done_port(done2),
    .S_oe_ram(oe2), .S_we_ram(we2), .S_addr_ram(addr2),
    .S_Wdata_ram(wdata2), .S_data_ram_size(size2),
    .Sout_Rdata_ram(rdata2), .Sout_DataRdy(rdy2),
    .chk_done(cdone2), .chk_pass(cpass2), .chk_timeout(ctmo2),
    .sim_cycles(sim2), .err_index(err2)
  );

  logic [31:0] mem1 [0:N-1];
  logic [31:0] mem2 [0:2];

  // memory model for dut1: latency fixed (lat1>0) or random {1,5,3}
  int          lat1     = 2;
  int          rnd_lat1 = 3;
  int          cnt1     = 0;
  int          lat_now1;
  int          ridx1;
  logic [31:0] rd1;
  logic [31:0] q1 = '0;

  assign lat_now1 = (lat1 != 0) ? lat1 : rnd_lat1;
  assign ridx1    = int'(addr1 >> 2);
  assign rd1      = (ridx1 < N) ? mem1[ridx1] : 32'hBAD0BAD0;

  function automatic int pick3();
    int k;
    k = int'($urandom_range(0, 2));
    return (k == 0) ? 1 : ((k == 1) ? 5 : 3);
  endfunction

  always @(posedge clock) begin
    rdy1 <= 1'b0;
    if (cnt1 == 1) begin
      rdy1   <= 1'b1;
      rdata1 <= {$urandom, q1};
    end
    if (cnt1 > 0) cnt1 <= cnt1 - 1;
    if (oe1) begin
      rnd_lat1 <= pick3();
      if (lat_now1 == 1) begin
        rdy1   <= 1'b1;
        rdata1 <= {$urandom, rd1};
        cnt1   <= 0;
      end else begin
        q1   <= rd1;
        cnt1 <= lat_now1 - 1;
      end
    end
  end

  // memory model for dut2: latency 2, 10-bit wrapping offset
  logic [9:0]  off2;
  logic [31:0] q2   = '0;
  int          cnt2 = 0;
  assign off2 = addr2 - 10'd1016;

  always @(posedge clock) begin
    rdy2 <= 1'b0;
    if (cnt2 == 1) begin
      rdy2   <= 1'b1;
      rdata2 <= {32'h5A5A5A5A, q2};
    end
    if (cnt2 > 0) cnt2 <= cnt2 - 1;
    if (oe2) begin
      q2   <= (off2[9:2] < 8'd3) ? mem2[off2[9:2]] : 32'hBAD0BAD0;
      cnt2 <= 1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // reference: first i with signed a[i] > a[i+1], else all-ones
  function automatic logic [15:0] model_err();
    for (int i = 0; i < N - 1; i++) begin
      if ($signed(mem1[i]) > $signed(mem1[i+1])) return 16'(i);
    end
    return 16'hFFFF;
  endfunction

  task automatic fill(input int pat);
    for (int i = 0; i < N; i++) begin
      case (pat)
        2: mem1[i] = (i == 0) ? 32'hFFFFFFFB :
                     (i == 1) ? 32'hFFFFFFFF :
                     (i == 2) ? 32'h0 : 32'(7 * (i - 2));
        3: mem1[i] = (i == 0) ? 32'h7FFFFFFF : 32'h80000000 + 32'(i - 1);
        4: mem1[i] = 32'hFFFFFFFD;
        default: mem1[i] = 32'(i);
      endcase
    end
    if (pat == 1) begin
      mem1[37] = 32'd1000;
      mem1[38] = 32'd5;
      mem1[80] = 32'd2000;
    end
    if (pat == 5) mem1[99] = 32'hFFFFFFFF;
  endtask

  task automatic pulse_start_done1(input int dly);
    @(negedge clock);
    start1 = 1'b1;
    @(negedge clock);
    start1 = 1'b0;
    repeat (dly - 1) @(negedge clock);
    done1 = 1'b1;
    @(negedge clock);
    done1 = 1'b0;
  endtask

  task automatic run1(input string tag, input int dly, input int lat,
                      input bit inj, input logic xp,
                      input logic [15:0] xe, input logic [31:0] xs);
    int cnt;
    int nrd;
    int bad;
    bit s_inj;
    bit d_inj;
    bit prev_oe;
    lat1 = lat;
    pulse_start_done1(dly);
    cnt = 1; nrd = 0; bad = 0;
    s_inj = 1'b0; d_inj = 1'b0; prev_oe = 1'b0;
    while (!cdone1 && cnt < 2000) begin
      if (oe1) begin
        if (addr1 != 10'(4 * nrd) || size1 != 7'd32 || prev_oe) bad++;
        nrd++;
      end else if (size1 != 7'd0) begin
        bad++;
      end
      if (we1 || wdata1 != 64'd0) bad++;
      prev_oe = oe1;
      start1 = 1'b0;
      done1  = 1'b0;
      if (inj && !s_inj && oe1 && nrd == 3) begin
        start1 = 1'b1;
        s_inj  = 1'b1;
      end
      if (inj && !d_inj && cnt == 50) begin
        done1 = 1'b1;
        d_inj = 1'b1;
      end
      @(negedge clock);
      cnt++;
    end
    start1 = 1'b0;
    done1  = 1'b0;
    chk({tag, "_done"}, cdone1, 1);
    chk({tag, "_pass"}, cpass1, xp);
    chk({tag, "_err"}, err1, xe);
    chk({tag, "_tmo"}, ctmo1, 0);
    chk({tag, "_sim"}, sim1, xs);
    chk({tag, "_nreads"}, nrd, N);
    chk({tag, "_rdshape"}, bad, 0);
    if (lat > 0) chk({tag, "_chktime"}, cnt, N * (lat + 2) + 1);
    @(negedge clock);
    chk({tag, "_hold"}, {cdone1, cpass1, err1}, {1'b1, xp, xe});
  endtask

  typedef struct {
    int          pat;
    int          dly;
    int          lat;
    bit          inj;
    logic        xp;
    logic [15:0] xe;
    logic [31:0] xs;
  } vec_t;

  vec_t vt [7];

  initial begin
    int cnt;
    int bad;
    bit oe_seen;

    vt[0] = '{0, 500, 2, 1'b0, 1'b1, 16'hFFFF, 32'd501};
    vt[1] = '{1, 10,  2, 1'b0, 1'b0, 16'd37,   32'd11};
    vt[2] = '{2, 1,   2, 1'b0, 1'b1, 16'hFFFF, 32'd2};
    vt[3] = '{3, 3,   2, 1'b0, 1'b0, 16'd0,    32'd4};
    vt[4] = '{4, 7,   1, 1'b0, 1'b1, 16'hFFFF, 32'd8};
    vt[5] = '{5, 4,   5, 1'b0, 1'b0, 16'd98,   32'd5};
    vt[6] = '{0, 500, 0, 1'b1, 1'b1, 16'hFFFF, 32'd501};

    fill(0);
    mem2[0] = 32'd5;
    mem2[1] = 32'd9;
    mem2[2] = 32'hFFFFFFFE;

    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_ctrl", {oe1, we1, addr1, size1}, 0);
    chk("rst_wdata", wdata1, 0);
    chk("rst_flags", {cdone1, cpass1, ctmo1}, 0);
    chk("rst_sim", sim1, 0);
    chk("rst_err", err1, 16'hFFFF);

    // timeout: done never arrives
    @(negedge clock);
    start2 = 1'b1;
    @(negedge clock);
    start2 = 1'b0;
    cnt = 1;
    oe_seen = 1'b0;
    while (!cdone2 && cnt < 200) begin
      if (oe2) oe_seen = 1'b1;
      @(negedge clock);
      cnt++;
    end
    chk("tmo_cycle", cnt, 50);
    chk("tmo_flag", ctmo2, 1);
    chk("tmo_pass", cpass2, 0);
    chk("tmo_sim", sim2, 50);
    chk("tmo_noread", oe_seen, 0);
    chk("tmo_err", err2, 16'hFFFF);

    // restart from FIN; reads wrap 1016, 1020, 0
    start2 = 1'b1;
    @(negedge clock);
    start2 = 1'b0;
    repeat (9) @(negedge clock);
    done2 = 1'b1;
    @(negedge clock);
    done2 = 1'b0;
    cnt = 1;
    bad = 0;
    oe_seen = 1'b0;
    while (!cdone2 && cnt < 200) begin
      if (oe2) begin
        if (addr2 != 10'(1016 + 4 * int'(oe_seen ? bad : 0))) bad = bad + 100;
        bad = bad + 1;
        oe_seen = 1'b1;
      end
      @(negedge clock);
      cnt++;
    end
    chk("wrap_reads", bad, 3);
    chk("wrap_chktime", cnt, 13);
    chk("wrap_flags", {cdone2, cpass2, ctmo2}, 3'b100);
    chk("wrap_err", err2, 16'd1);
    chk("wrap_sim", sim2, 11);

    for (int t = 0; t < 7; t++) begin
      fill(vt[t].pat);
      run1($sformatf("vec%0d", t), vt[t].dly, vt[t].lat, vt[t].inj,
           vt[t].xp, vt[t].xe, vt[t].xs);
    end

    // async reset while the read strobe is up
    fill(0);
    lat1 = 2;
    pulse_start_done1(5);
    chk("rstrd_oe_pre", oe1, 1);
    reset = 1'b1;
    #1;
    chk("rstrd_oe", oe1, 0);
    chk("rstrd_sim", sim1, 0);
    #2 reset = 1'b0;

    // async reset in WT with the read still in flight
    pulse_start_done1(5);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rstwt_ctrl", {oe1, addr1, size1}, 0);
    chk("rstwt_res", {cdone1, cpass1, ctmo1, sim1, err1},
        {3'b000, 32'd0, 16'hFFFF});
    #2 reset = 1'b0;
    bad = 0;
    repeat (4) begin
      @(negedge clock);
      if (oe1 || cdone1 || sim1 != 32'd0) bad++;
    end
    chk("rstwt_stale", bad, 0);
    run1("after_rst", 20, 2, 1'b0, 1'b1, 16'hFFFF, 32'd21);

    // random arrays against the reference model
    for (int r = 0; r < 6; r++) begin
      int dly;
      int lat;
      int j;
      logic [15:0] xe;
      dly = int'($urandom_range(1, 300));
      lat = int'($urandom_range(0, 5));
      mem1[0] = 32'hFFFF0000 + 32'($urandom_range(0, 1000));
      for (int i = 1; i < N; i++) begin
        mem1[i] = mem1[i-1] + 32'($urandom_range(0, 3000));
      end
      if (r % 2 == 1) begin
        j = int'($urandom_range(0, N - 2));
        mem1[j] = mem1[j+1] + 32'd1 + 32'($urandom_range(0, 5));
        j = int'($urandom_range(0, N - 2));
        mem1[j] = mem1[j+1] + 32'd1 + 32'($urandom_range(0, 5));
      end
      xe = model_err();
      run1($sformatf("rnd%0d", r), dly, lat, 1'b0, (xe == 16'hFFFF),
           xe, 32'(dly + 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
